// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - memory-stage, scanout and memory I/O signals of the data-memory arbiter
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic [1:0]        mem_wren;
  logic [ADDR_W-1:0] mem_addr_in;
  logic [DATA_W-1:0] mem_wdata_in;
  logic [DATA_W-1:0] mem_rdata_out;
  logic              mem_rvalid;
  logic              mem_stall;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_rvalid;
  logic [ADDR_W-1:0] bus_addr;
  logic [1:0]        bus_wren;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  // master: requesters plus memory I/O unit; slave: the arbiter
  modport master (
    output mem_req, mem_wren, mem_addr_in, mem_wdata_in, vid_req, vid_addr, bus_rdata,
    input  mem_rdata_out, mem_rvalid, mem_stall, vid_gnt, vid_rdata, vid_rvalid,
    input  bus_addr, bus_wren, bus_wdata
  );

  modport slave (
    input  mem_req, mem_wren, mem_addr_in, mem_wdata_in, vid_req, vid_addr, bus_rdata,
    output mem_rdata_out, mem_rvalid, mem_stall, vid_gnt, vid_rdata, vid_rvalid,
    output bus_addr, bus_wren, bus_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - scanout-priority arbiter for the single-ported data memory
module mem_bus_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 16,
  parameter int MAX_VID_RUN = 4
) (
  input  logic              clock,
  input  logic              nreset,
  mem_bus_arbiter_if.slave  arb
);
  typedef enum logic {M_IDLE, M_RD_WAIT} state_t;

  localparam logic [3:0] RUN_MAX = 4'(MAX_VID_RUN);

  state_t            state, state_nxt;
  logic [3:0]        run_cnt, run_cnt_nxt;
  logic              mem_req_v, vid_req_v, mem_load, mem_elig;
  logic              vid_gnt_int, mem_gnt_int;
  logic              rd_issued, rd_owner_vid;
  logic              mem_rvalid_int, vid_rvalid_int;
  logic [DATA_W-1:0] mem_rdata_hold, vid_rdata_hold;
  logic [ADDR_W-1:0] bus_addr_hold, bus_addr_sel;

  // Requests are masked during reset so every combinational output reads idle.
  always_comb begin
    mem_req_v   = arb.mem_req & nreset;
    vid_req_v   = arb.vid_req & nreset;
    mem_load    = (arb.mem_wren == 2'b00);
    mem_elig    = mem_req_v & (state == M_IDLE);
    vid_gnt_int = vid_req_v & ~(mem_elig & (run_cnt == RUN_MAX));
    mem_gnt_int = mem_elig & ~vid_gnt_int;

    state_nxt   = M_IDLE;
    if ((state == M_IDLE) && mem_gnt_int && mem_load) begin
      state_nxt = M_RD_WAIT;
    end

    run_cnt_nxt = run_cnt;
    if (!mem_req_v || mem_gnt_int) begin
      run_cnt_nxt = '0;
    end else if (vid_gnt_int && (state == M_IDLE) && (run_cnt < RUN_MAX)) begin
      run_cnt_nxt = run_cnt + 4'd1;
    end

    bus_addr_sel = bus_addr_hold;
    if (vid_gnt_int) begin
      bus_addr_sel = arb.vid_addr;
    end else if (mem_gnt_int) begin
      bus_addr_sel = arb.mem_addr_in;
    end

    mem_rvalid_int = nreset & rd_issued & ~rd_owner_vid;
    vid_rvalid_int = nreset & rd_issued & rd_owner_vid;
  end

  assign arb.vid_gnt       = vid_gnt_int;
  assign arb.mem_stall     = (mem_elig & ~mem_gnt_int) | (mem_gnt_int & mem_load);
  assign arb.bus_addr      = bus_addr_sel;
  assign arb.bus_wren      = mem_gnt_int ? arb.mem_wren : 2'b00;
  assign arb.bus_wdata     = arb.mem_wdata_in;
  assign arb.mem_rvalid    = mem_rvalid_int;
  assign arb.vid_rvalid    = vid_rvalid_int;
  assign arb.mem_rdata_out = mem_rvalid_int ? arb.bus_rdata : mem_rdata_hold;
  assign arb.vid_rdata     = vid_rvalid_int ? arb.bus_rdata : vid_rdata_hold;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state          <= M_IDLE;
      run_cnt        <= '0;
      rd_issued      <= 1'b0;
      rd_owner_vid   <= 1'b0;
      mem_rdata_hold <= '0;
      vid_rdata_hold <= '0;
      bus_addr_hold  <= '0;
    end else begin
      state          <= state_nxt;
      run_cnt        <= run_cnt_nxt;
      rd_issued      <= vid_gnt_int | (mem_gnt_int & mem_load);
      rd_owner_vid   <= vid_gnt_int;
      bus_addr_hold  <= bus_addr_sel;
      if (mem_rvalid_int) begin
        mem_rdata_hold <= arb.bus_rdata;
      end
      if (vid_rvalid_int) begin
        vid_rdata_hold <= arb.bus_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  localparam int ADDR_W      = 17;
  localparam int DATA_W      = 16;
  localparam int MAX_VID_RUN = 4;

  logic clock  = 1'b0;
  logic nreset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if ();

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_VID_RUN(MAX_VID_RUN)) dut (
    .clock  (clock),
    .nreset (nreset),
    .arb    (u_if.slave)
  );

  // Memory contents before any store; 0x1_0040 is preloaded with 0x00A5
  function automatic logic [15:0] seed_word(input logic [16:0] a);
    if (a == 17'h10040) return 16'h00A5;
    return {a[7:0], a[15:8]} ^ {15'h2C3, a[16]};
  endfunction

  function automatic logic [15:0] merge_word(input logic [15:0] old, input logic [15:0] nw,
                                             input logic [1:0] we);
    logic [15:0] r;
    r = old;
    if (we[1]) r[15:8] = nw[15:8];
    if (we[0]) r[7:0]  = nw[7:0];
    return r;
  endfunction

  // Memory I/O unit emulation driven by the DUT bus
  logic [15:0] bus_img [0:131071];
  bit          bus_wr  [0:131071];

  function automatic logic [15:0] bus_read(input logic [16:0] a);
    return bus_wr[a] ? bus_img[a] : seed_word(a);
  endfunction

  always @(posedge clock) begin
    if ($isunknown(u_if.bus_addr) || $isunknown(u_if.bus_wren)) begin
      u_if.bus_rdata <= '0;
    end else begin
      u_if.bus_rdata <= bus_read(u_if.bus_addr);
      if (u_if.bus_wren != 2'b00) begin
        bus_img[u_if.bus_addr] <= merge_word(bus_read(u_if.bus_addr), u_if.bus_wdata, u_if.bus_wren);
        bus_wr[u_if.bus_addr]  <= 1'b1;
      end
    end
  end

  // Reference model: memory image plus the arbitration rules in plain terms
  logic [15:0] ref_img [0:131071];
  bit          ref_wr  [0:131071];

  function automatic logic [15:0] ref_read(input logic [16:0] a);
    return ref_wr[a] ? ref_img[a] : seed_word(a);
  endfunction

  logic        m_load_pending = 1'b0;
  int          m_streak       = 0;
  int          m_ret_kind     = 0;
  logic [15:0] m_ret_data     = '0;
  logic [15:0] m_held_mem     = '0;
  logic [15:0] m_held_vid     = '0;
  logic [16:0] m_last_addr    = '0;

  logic        e_vid_gnt, e_mem_gnt, e_stall, e_mem_rvalid, e_vid_rvalid;
  logic [1:0]  e_bus_wren;
  logic [16:0] e_bus_addr;
  logic [15:0] e_mem_rdata, e_vid_rdata;

  task automatic model_eval();
    logic mem_elig;
    mem_elig     = u_if.mem_req && nreset && !m_load_pending;
    e_vid_gnt    = u_if.vid_req && nreset && !(mem_elig && m_streak == MAX_VID_RUN);
    e_mem_gnt    = mem_elig && !e_vid_gnt;
    e_stall      = (mem_elig && !e_mem_gnt) || (e_mem_gnt && u_if.mem_wren == 2'b00);
    e_bus_wren   = e_mem_gnt ? u_if.mem_wren : 2'b00;
    e_bus_addr   = e_vid_gnt ? u_if.vid_addr : (e_mem_gnt ? u_if.mem_addr_in : m_last_addr);
    e_mem_rvalid = nreset && m_ret_kind == 1;
    e_vid_rvalid = nreset && m_ret_kind == 2;
    e_mem_rdata  = e_mem_rvalid ? m_ret_data : m_held_mem;
    e_vid_rdata  = e_vid_rvalid ? m_ret_data : m_held_vid;
  endtask

  task automatic model_commit();
    logic load;
    if (!nreset) begin
      m_load_pending = 1'b0; m_streak = 0; m_ret_kind = 0;
      m_held_mem = '0; m_held_vid = '0; m_last_addr = '0;
      return;
    end
    load = (u_if.mem_wren == 2'b00);
    if (e_mem_rvalid) m_held_mem = m_ret_data;
    if (e_vid_rvalid) m_held_vid = m_ret_data;
    m_last_addr = e_bus_addr;
    if (e_vid_gnt) begin
      m_ret_kind = 2; m_ret_data = ref_read(u_if.vid_addr);
    end else if (e_mem_gnt && load) begin
      m_ret_kind = 1; m_ret_data = ref_read(u_if.mem_addr_in);
    end else begin
      m_ret_kind = 0;
    end
    if (e_mem_gnt && !load) begin
      ref_img[u_if.mem_addr_in] = merge_word(ref_read(u_if.mem_addr_in), u_if.mem_wdata_in, u_if.mem_wren);
      ref_wr[u_if.mem_addr_in]  = 1'b1;
    end
    if (!u_if.mem_req || e_mem_gnt) m_streak = 0;
    else if (e_vid_gnt && !m_load_pending && m_streak < MAX_VID_RUN) m_streak++;
    m_load_pending = e_mem_gnt && load;
  endtask

  task automatic idle_inputs();
    u_if.mem_req = 1'b0; u_if.mem_wren = 2'b00; u_if.mem_addr_in = '0; u_if.mem_wdata_in = '0;
    u_if.vid_req = 1'b0; u_if.vid_addr = '0;
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic drain();
    next_cycle(); idle_inputs(); settle(); model_commit();
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle_inputs(); settle(); model_commit();
    end
    next_cycle(); nreset = 1'b1; idle_inputs(); settle();
    n_checks++; if (u_if.mem_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rvalid: got %b want 0", u_if.mem_rvalid); end
    n_checks++; if (u_if.vid_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_vid_rvalid: got %b want 0", u_if.vid_rvalid); end
    n_checks++; if (u_if.mem_rdata_out !== 16'h0) begin n_fail++; $display("FAIL reset_mem_rdata: got %h want 0", u_if.mem_rdata_out); end
    n_checks++; if (u_if.vid_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_vid_rdata: got %h want 0", u_if.vid_rdata); end
    n_checks++; if (u_if.bus_addr !== 17'h0) begin n_fail++; $display("FAIL reset_bus_addr: got %h want 0", u_if.bus_addr); end
    n_checks++; if (u_if.bus_wren !== 2'b00) begin n_fail++; $display("FAIL reset_bus_wren: got %b want 00", u_if.bus_wren); end
    n_checks++; if (u_if.vid_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_vid_gnt: got %b want 0", u_if.vid_gnt); end
    n_checks++; if (u_if.mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_mem_stall: got %b want 0", u_if.mem_stall); end
    model_commit();
  endtask

  task automatic test_store();
    logic [16:0] a;
    logic [15:0] d;
    next_cycle(); idle_inputs();
    u_if.mem_req = 1'b1; u_if.mem_wren = 2'b11; u_if.mem_addr_in = 17'h01234; u_if.mem_wdata_in = 16'hBEEF;
    settle();
    n_checks++; if (u_if.bus_wren !== 2'b11) begin n_fail++; $display("FAIL store_wren: got %b want 11", u_if.bus_wren); end
    n_checks++; if (u_if.bus_addr !== 17'h01234) begin n_fail++; $display("FAIL store_addr: got %h want 01234", u_if.bus_addr); end
    n_checks++; if (u_if.bus_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL store_wdata: got %h want beef", u_if.bus_wdata); end
    n_checks++; if (u_if.mem_stall !== 1'b0) begin n_fail++; $display("FAIL store_stall: got %b want 0", u_if.mem_stall); end
    model_commit();
    for (int i = 0; i < 4; i++) begin
      a = {1'b0, 16'($urandom)};
      d = 16'($urandom);
      next_cycle(); u_if.mem_wren = 2'($urandom_range(1, 3)); u_if.mem_addr_in = a; u_if.mem_wdata_in = d;
      settle();
      n_checks++; if (u_if.mem_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall[%0d]: got %b want 0", i, u_if.mem_stall); end
      n_checks++; if (u_if.bus_addr !== a) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, u_if.bus_addr, a); end
      n_checks++; if (u_if.bus_wren !== u_if.mem_wren) begin n_fail++; $display("FAIL b2b_wren[%0d]: got %b want %b", i, u_if.bus_wren, u_if.mem_wren); end
      model_commit();
    end
    drain();
  endtask

  task automatic test_load();
    next_cycle(); idle_inputs();
    u_if.mem_req = 1'b1; u_if.mem_wren = 2'b00; u_if.mem_addr_in = 17'h10040;
    settle();
    n_checks++; if (u_if.mem_stall !== 1'b1) begin n_fail++; $display("FAIL load_stall_c0: got %b want 1", u_if.mem_stall); end
    n_checks++; if (u_if.bus_addr !== 17'h10040) begin n_fail++; $display("FAIL load_addr: got %h want 10040", u_if.bus_addr); end
    n_checks++; if (u_if.bus_wren !== 2'b00) begin n_fail++; $display("FAIL load_wren: got %b want 00", u_if.bus_wren); end
    model_commit();
    next_cycle(); idle_inputs(); settle();
    n_checks++; if (u_if.mem_rvalid !== 1'b1) begin n_fail++; $display("FAIL load_rvalid_c1: got %b want 1", u_if.mem_rvalid); end
    n_checks++; if (u_if.mem_rdata_out !== 16'h00A5) begin n_fail++; $display("FAIL load_rdata_c1: got %h want 00a5", u_if.mem_rdata_out); end
    n_checks++; if (u_if.mem_stall !== 1'b0) begin n_fail++; $display("FAIL load_stall_c1: got %b want 0", u_if.mem_stall); end
    model_commit();
    next_cycle(); idle_inputs(); settle();
    n_checks++; if (u_if.mem_rvalid !== 1'b0) begin n_fail++; $display("FAIL load_rvalid_c2: got %b want 0", u_if.mem_rvalid); end
    n_checks++; if (u_if.mem_rdata_out !== 16'h00A5) begin n_fail++; $display("FAIL load_rdata_hold: got %h want 00a5", u_if.mem_rdata_out); end
    model_commit();
  endtask

  task automatic test_contention();
    logic [6:0] want_vid;
    int         stalls;
    want_vid = 7'b1101111;
    stalls   = 0;
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      u_if.vid_req = 1'b1; u_if.vid_addr = 17'($urandom);
      u_if.mem_req = 1'b1; u_if.mem_wren = 2'b01; u_if.mem_addr_in = 17'h00777; u_if.mem_wdata_in = 16'h5A3C;
      settle();
      n_checks++; if (u_if.vid_gnt !== want_vid[c]) begin n_fail++; $display("FAIL cont_vid_gnt[%0d]: got %b want %b", c, u_if.vid_gnt, want_vid[c]); end
      n_checks++; if (u_if.bus_wren !== ((c == 4) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL cont_wren[%0d]: got %b", c, u_if.bus_wren); end
      if (c < 4 && u_if.mem_stall === 1'b1) stalls++;
      if (c == 4) begin
        n_checks++; if (u_if.mem_stall !== 1'b0) begin n_fail++; $display("FAIL cont_stall_at_grant: got %b want 0", u_if.mem_stall); end
      end
      model_commit();
    end
    n_checks++; if (stalls != 4) begin n_fail++; $display("FAIL cont_stall_cycles: got %0d want 4", stalls); end
    drain();
  endtask

  task automatic test_scanout_stream();
    for (int i = 0; i < 9; i++) begin
      next_cycle(); idle_inputs();
      u_if.vid_req = (i < 8); u_if.vid_addr = 17'h10000 + 17'(i);
      settle();
      n_checks++; if (u_if.vid_gnt !== (i < 8)) begin n_fail++; $display("FAIL stream_gnt[%0d]: got %b", i, u_if.vid_gnt); end
      n_checks++; if (u_if.vid_rvalid !== (i >= 1)) begin n_fail++; $display("FAIL stream_rvalid[%0d]: got %b", i, u_if.vid_rvalid); end
      if (i < 8) begin
        n_checks++; if (u_if.bus_addr !== u_if.vid_addr || u_if.bus_wren !== 2'b00) begin n_fail++; $display("FAIL stream_bus[%0d]: got %h/%b want %h/00", i, u_if.bus_addr, u_if.bus_wren, u_if.vid_addr); end
      end
      if (i >= 1) begin
        n_checks++; if (u_if.vid_rdata !== ref_read(17'h10000 + 17'(i - 1))) begin n_fail++; $display("FAIL stream_rdata[%0d]: got %h want %h", i, u_if.vid_rdata, ref_read(17'h10000 + 17'(i - 1))); end
      end
      model_commit();
    end
  endtask

  task automatic test_load_interleave();
    logic [16:0] x, y;
    int          mp, vp;
    x = 17'h12000 + 17'($urandom_range(0, 255));
    y = 17'h04000 + 17'($urandom_range(0, 255));
    mp = 0; vp = 0;
    for (int c = 0; c < 4; c++) begin
      next_cycle(); idle_inputs();
      if (c == 0) begin u_if.mem_req = 1'b1; u_if.mem_addr_in = x; end
      if (c == 1) begin u_if.vid_req = 1'b1; u_if.vid_addr = y; end
      settle();
      if (u_if.mem_rvalid === 1'b1) mp++;
      if (u_if.vid_rvalid === 1'b1) vp++;
      if (c == 1) begin
        n_checks++; if (u_if.vid_gnt !== 1'b1) begin n_fail++; $display("FAIL ilv_vid_gnt: got %b want 1", u_if.vid_gnt); end
        n_checks++; if (u_if.mem_rvalid !== 1'b1 || u_if.mem_rdata_out !== ref_read(x)) begin n_fail++; $display("FAIL ilv_mem_ret: got %b/%h want 1/%h", u_if.mem_rvalid, u_if.mem_rdata_out, ref_read(x)); end
      end
      if (c == 2) begin
        n_checks++; if (u_if.vid_rvalid !== 1'b1 || u_if.vid_rdata !== ref_read(y)) begin n_fail++; $display("FAIL ilv_vid_ret: got %b/%h want 1/%h", u_if.vid_rvalid, u_if.vid_rdata, ref_read(y)); end
      end
      model_commit();
    end
    n_checks++; if (mp != 1 || vp != 1) begin n_fail++; $display("FAIL ilv_pulse_count: got mem %0d vid %0d want 1 1", mp, vp); end
  endtask

  task automatic test_reset_mid_load();
    next_cycle(); idle_inputs();
    u_if.mem_req = 1'b1; u_if.mem_addr_in = 17'h10040;
    settle();
    n_checks++; if (u_if.mem_stall !== 1'b1) begin n_fail++; $display("FAIL rml_stall_c0: got %b want 1", u_if.mem_stall); end
    model_commit();
    next_cycle(); idle_inputs(); nreset = 1'b0; settle(); model_commit();
    next_cycle(); idle_inputs(); nreset = 1'b1; settle();
    n_checks++; if (u_if.mem_rvalid !== 1'b0 || u_if.vid_rvalid !== 1'b0) begin n_fail++; $display("FAIL rml_rvalid: got %b/%b want 0/0", u_if.mem_rvalid, u_if.vid_rvalid); end
    n_checks++; if (u_if.mem_stall !== 1'b0) begin n_fail++; $display("FAIL rml_stall: got %b want 0", u_if.mem_stall); end
    n_checks++; if (u_if.mem_rdata_out !== 16'h0 || u_if.vid_rdata !== 16'h0) begin n_fail++; $display("FAIL rml_rdata: got %h/%h want 0/0", u_if.mem_rdata_out, u_if.vid_rdata); end
    n_checks++; if (u_if.bus_addr !== 17'h0) begin n_fail++; $display("FAIL rml_bus_addr: got %h want 0", u_if.bus_addr); end
    model_commit();
    next_cycle(); idle_inputs();
    u_if.mem_req = 1'b1; u_if.mem_wren = 2'b11; u_if.mem_addr_in = 17'h00042; u_if.mem_wdata_in = 16'h1357;
    settle();
    n_checks++; if (u_if.bus_wren !== 2'b11 || u_if.mem_stall !== 1'b0) begin n_fail++; $display("FAIL rml_idle_store: got %b/%b want 11/0", u_if.bus_wren, u_if.mem_stall); end
    model_commit();
    drain();
  endtask

  task automatic test_random();
    logic holding;
    holding = 1'b0;
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      if (m_load_pending) begin
        u_if.mem_req = 1'b0;
      end else begin
        if (!holding && $urandom_range(0, 99) < 60) begin
          holding = 1'b1;
          u_if.mem_wren     = 2'($urandom_range(0, 3));
          u_if.mem_addr_in  = {1'($urandom_range(0, 1)), 12'h0, 4'($urandom_range(0, 15))};
          u_if.mem_wdata_in = 16'($urandom);
        end
        u_if.mem_req = holding;
      end
      u_if.vid_req  = ($urandom_range(0, 99) < 70);
      u_if.vid_addr = {1'($urandom_range(0, 1)), 12'h0, 4'($urandom_range(0, 15))};
      settle();
      n_checks++; if (u_if.vid_gnt !== e_vid_gnt) begin n_fail++; $display("FAIL rnd_vid_gnt[%0d]: got %b want %b", c, u_if.vid_gnt, e_vid_gnt); end
      n_checks++; if (u_if.mem_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %b want %b", c, u_if.mem_stall, e_stall); end
      n_checks++; if (u_if.bus_wren !== e_bus_wren) begin n_fail++; $display("FAIL rnd_wren[%0d]: got %b want %b", c, u_if.bus_wren, e_bus_wren); end
      n_checks++; if (u_if.bus_addr !== e_bus_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, u_if.bus_addr, e_bus_addr); end
      if (e_bus_wren != 2'b00) begin
        n_checks++; if (u_if.bus_wdata !== u_if.mem_wdata_in) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", c, u_if.bus_wdata, u_if.mem_wdata_in); end
      end
      n_checks++; if (u_if.mem_rvalid !== e_mem_rvalid) begin n_fail++; $display("FAIL rnd_mem_rvalid[%0d]: got %b want %b", c, u_if.mem_rvalid, e_mem_rvalid); end
      n_checks++; if (u_if.mem_rdata_out !== e_mem_rdata) begin n_fail++; $display("FAIL rnd_mem_rdata[%0d]: got %h want %h", c, u_if.mem_rdata_out, e_mem_rdata); end
      n_checks++; if (u_if.vid_rvalid !== e_vid_rvalid) begin n_fail++; $display("FAIL rnd_vid_rvalid[%0d]: got %b want %b", c, u_if.vid_rvalid, e_vid_rvalid); end
      n_checks++; if (u_if.vid_rdata !== e_vid_rdata) begin n_fail++; $display("FAIL rnd_vid_rdata[%0d]: got %h want %h", c, u_if.vid_rdata, e_vid_rdata); end
      if (e_mem_gnt) holding = 1'b0;
      model_commit();
    end
    drain();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_store();
    test_load();
    test_contention();
    test_scanout_stream();
    test_load_interleave();
    test_reset_mid_load();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
